// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_pkg;

    localparam int unsigned CNT_W    = 16;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        LU_STALL = 2'd2
    } state_t;

    // Saturating increment for the status counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparison: a load in ID/EX whose destination feeds the
// instruction in ID. Register zero never creates a dependency.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic       mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    // Pure combinational match of load destination against both sources.
    always_comb begin
        hazard = mem_read && (ex_rt != REG_ZERO) &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control FSM: memory stalls, taken-branch flushes and single
// load-use bubbles, plus saturating stall/flush counters.
module pipeline_ctrl
    import pipeline_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [4:0]       IdRs,
    input  logic [4:0]       IdRt,
    input  logic             ExMemRead,
    input  logic [4:0]       ExRt,
    input  logic             MemBranch,
    input  logic             MemZero,
    input  logic             MemAccess,
    input  logic             MemReady,
    output logic             PcWrite,
    output logic             PcSel,
    output logic             IfIdWrite,
    output logic             IdExWrite,
    output logic             ExMemWrite,
    output logic             MemWbWrite,
    output logic             IfIdFlush,
    output logic             IdExFlush,
    output logic             ExMemFlush,
    output logic             MemReq,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic [1:0]       State
);

    state_t state, state_nxt;
    logic   lu_hazard;
    logic   mem_stall;
    logic   br_taken;

    hazard_detect u_hazard (
        .mem_read (ExMemRead),
        .ex_rt    (ExRt),
        .id_rs    (IdRs),
        .id_rt    (IdRt),
        .hazard   (lu_hazard)
    );

    assign mem_stall = MemAccess && !MemReady;
    assign br_taken  = MemBranch && MemZero;
    assign State     = state;

    // State register; reset abandons any wait or bubble in progress.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // Saturating counters of stalled-PC cycles and taken branches.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (!PcWrite) StallCount <= sat_inc(StallCount);
            if (PcSel)    FlushCount <= sat_inc(FlushCount);
        end
    end

    // Next-state and control decode; priority is memory, branch, load-use.
    always_comb begin
        state_nxt  = RUN;
        PcWrite    = 1'b1;
        PcSel      = 1'b0;
        IfIdWrite  = 1'b1;
        IdExWrite  = 1'b1;
        ExMemWrite = 1'b1;
        MemWbWrite = 1'b1;
        IfIdFlush  = 1'b0;
        IdExFlush  = 1'b0;
        ExMemFlush = 1'b0;
        MemReq     = MemAccess;

        case (state)
            RUN, LU_STALL: begin
                if (mem_stall) begin
                    MemReq     = 1'b1;
                    PcWrite    = 1'b0;
                    IfIdWrite  = 1'b0;
                    IdExWrite  = 1'b0;
                    ExMemWrite = 1'b0;
                    MemWbWrite = 1'b0;
                    state_nxt  = MEM_WAIT;
                end else if (br_taken) begin
                    PcSel      = 1'b1;
                    IfIdFlush  = 1'b1;
                    IdExFlush  = 1'b1;
                    ExMemFlush = 1'b1;
                end else if ((state == RUN) && lu_hazard) begin
                    PcWrite    = 1'b0;
                    IfIdWrite  = 1'b0;
                    IdExFlush  = 1'b1;
                    state_nxt  = LU_STALL;
                end
            end
            MEM_WAIT: begin
                if (!MemReady) begin
                    MemReq     = 1'b1;
                    PcWrite    = 1'b0;
                    IfIdWrite  = 1'b0;
                    IdExWrite  = 1'b0;
                    ExMemWrite = 1'b0;
                    MemWbWrite = 1'b0;
                    state_nxt  = MEM_WAIT;
                end else if (br_taken) begin
                    PcSel      = 1'b1;
                    IfIdFlush  = 1'b1;
                    IdExFlush  = 1'b1;
                    ExMemFlush = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase

        // Reset holds the pipeline frozen and flushing regardless of state.
        if (!Rst_n) begin
            PcWrite    = 1'b0;
            PcSel      = 1'b0;
            IfIdWrite  = 1'b0;
            IdExWrite  = 1'b0;
            ExMemWrite = 1'b0;
            MemWbWrite = 1'b0;
            IfIdFlush  = 1'b1;
            IdExFlush  = 1'b1;
            ExMemFlush = 1'b1;
            MemReq     = 1'b0;
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
- Clk  in  1  rising-edge clock, shared with the pipeline registers.
- Rst_n  in  1  asynchronous active-low reset.
REQ-002 The block SHALL provide these hazard-detection and status inputs.
- IdRs, IdRt  in  5 each  source registers of the instruction in ID.
- ExMemRead  in  1  ID/EX holds a load.
- ExRt  in  5  destination register of that load.
- MemBranch, MemZero  in  1 each  EX/MEM branch flag and zero flag.
- MemAccess  in  1  EX/MEM holds a load or a store.
- MemReady  in  1  data memory has completed the access.
REQ-003 The block SHALL provide these pipeline-control outputs.
- PcWrite  out  1  PC update enable.
- PcSel  out  1  1 selects the EX/MEM branch target.
- IfIdWrite, IdExWrite, ExMemWrite, MemWbWrite  out  1 each  pipeline register enables.
- IfIdFlush, IdExFlush, ExMemFlush  out  1 each  synchronous bubble insert.
- MemReq  out  1  data memory request.
REQ-004 The block SHALL provide these status outputs.
- StallCount  out  16  cycles with PcWrite=0.
- FlushCount  out  16  taken branches.
- State  out  2  current FSM state.

Function
REQ-005 The FSM SHALL have three states, with state registered and all control outputs decoded combinationally from state and inputs.
- RUN
- MEM_WAIT
- LU_STALL
REQ-006 The default outputs (no event) SHALL be:
- all Write signals = 1
- all Flush signals = 0
- PcSel = 0
- MemReq = MemAccess
REQ-007 In RUN, when MemAccess=1 and MemReady=0, the block SHALL:
- assert MemReq=1
- drive PcWrite and all four Write signals to 0
- assert no flush
- move to MEM_WAIT.
REQ-008 In MEM_WAIT, the block SHALL hold MemReq=1 and all Write signals at 0 until MemReady=1. In that cycle it SHALL apply the REQ-006 defaults plus any taken-branch action, then return to RUN.
REQ-009 A taken branch (MemBranch=1 and MemZero=1), when not stalled by memory, SHALL in the same cycle drive PcSel=1, IfIdFlush=1, IdExFlush=1 and ExMemFlush=1.
REQ-010 A load-use hazard SHALL be ExMemRead=1, ExRt!=0 and (ExRt==IdRs or ExRt==IdRt).
REQ-011 On a load-use hazard in RUN, with no memory stall and no taken branch, the block SHALL:
- drive PcWrite=0 and IfIdWrite=0
- drive IdExFlush=1
- move to LU_STALL.
REQ-012 In LU_STALL, hazard detection SHALL be disabled, giving exactly one bubble. The memory and branch rules SHALL still apply as in RUN, and the next state SHALL be RUN, or MEM_WAIT per REQ-007.
REQ-013 Priority SHALL be: memory stall, then taken branch, then load-use. A taken branch suppresses a simultaneous load-use stall.
REQ-014 StallCount SHALL increment in every cycle with PcWrite=0 and saturate at 16'hFFFF.
REQ-015 FlushCount SHALL increment once per cycle with PcSel=1 and saturate at 16'hFFFF.
REQ-016 State encoding SHALL be RUN=0, MEM_WAIT=1, LU_STALL=2. Encoding 3 is illegal and SHALL recover to RUN on the next edge.

Reset
REQ-017 Rst_n=0 SHALL immediately, without waiting for a clock edge:
- force State=RUN
- clear StallCount and FlushCount to 0.
REQ-018 While Rst_n=0, the block SHALL drive:
- all Write signals and PcWrite = 0
- all Flush signals = 1
- PcSel = 0 and MemReq = 0.
REQ-019 A reset asserted mid-MEM_WAIT or mid-LU_STALL SHALL abandon the operation, and the block SHALL resume in RUN after Rst_n rises.

Structure
REQ-020 A shared package pipeline_pkg SHALL hold:
- the state type and encodings
- REG_ZERO = 5'd0
- CNT_W = 16.
REQ-021 The load-use comparison SHALL be a separate combinational sub-module named hazard_detect. Everything else SHALL live in pipeline_ctrl.

Verification
REQ-022 Load-use: ExMemRead=1, ExRt=5, IdRs=5 in RUN -> one cycle with PcWrite=0, IfIdWrite=0, IdExFlush=1; State=2 then 0; StallCount=1.
REQ-023 Zero-register case: ExMemRead=1, ExRt=0, IdRt=0 -> no stall; State stays 0.
REQ-024 Memory wait: MemAccess=1, MemReady low for 3 cycles -> MemReq=1 for 4 cycles; all Write=0 for 3 cycles; State=1; StallCount=3.
REQ-025 Branch vs load-use: MemBranch=1, MemZero=1 together with a load-use hazard -> PcSel=1, three flushes, PcWrite=1, no LU_STALL; FlushCount=1.
REQ-026 Reset mid-wait: Rst_n pulsed low during MEM_WAIT -> State=0 and counters=0 without a clock edge; Flush signals=1 while low.
REQ-027 Saturation: StallCount preloaded to 16'hFFFE by forcing a stall for 65534 cycles, then 3 more stall cycles -> StallCount=16'hFFFF.
